// File: rtl/lift_request_scheduler_if.sv
// Command channel between the hall-call scheduler and the car controller.
// The car owns floor position; the scheduler only offers target floors.
interface lift_request_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd_floor;
  logic       cmd_ready;
  logic       arrived;
  logic [2:0] cur_floor;

  modport master (
    output cmd_valid, cmd_floor,
    input  cmd_ready, arrived, cur_floor
  );

  modport slave (
    input  cmd_valid, cmd_floor,
    output cmd_ready, arrived, cur_floor
  );
endinterface

// File: rtl/lift_request_scheduler.sv
// SCAN hall-call scheduler: latches floor requests, offers the next target to the
// car over a valid/ready channel, and holds the door for a fixed dwell on arrival.
module lift_request_scheduler #(
  parameter int unsigned NFLOORS     = 5,
  parameter int unsigned DOOR_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NFLOORS-1:0]       req,
  lift_request_scheduler_if.master car,
  output logic                     door_open,
  output logic                     dir,
  output logic [NFLOORS-1:0]       pending,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, TRAVEL, DOOR} state_t;

  localparam int unsigned CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [NFLOORS-1:0] pend_n;
  logic               dir_n;
  logic               cmd_valid_q, cmd_valid_n;
  logic [2:0]         cmd_floor_q, cmd_floor_n;

  logic               cur_ok;
  logic [NFLOORS-1:0] cur_mask;
  logic               up_found, dn_found;
  logic [2:0]         up_floor, dn_floor;

  // Nearest pending floor on each side of the car; an out-of-range cur_floor
  // yields an empty cur_mask so it never matches a request.
  always_comb begin
    cur_ok   = 32'(car.cur_floor) < NFLOORS;
    cur_mask = '0;
    up_found = 1'b0;
    dn_found = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    for (int unsigned i = 0; i < NFLOORS; i++) begin
      if (i == 32'(car.cur_floor)) cur_mask[i] = 1'b1;
      if (pending[i] && (i > 32'(car.cur_floor)) && !up_found) begin
        up_found = 1'b1;
        up_floor = 3'(i);
      end
      if (pending[i] && (i < 32'(car.cur_floor))) begin
        dn_found = 1'b1;
        dn_floor = 3'(i);
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dir_n       = dir;
    cmd_valid_n = cmd_valid_q;
    cmd_floor_n = cmd_floor_q;
    pend_n      = pending | req;
    unique case (state)
      IDLE: begin
        if (|(pending & cur_mask)) begin
          state_n = DOOR;
          cnt_n   = CW'(DOOR_CYCLES - 1);
        end else if ((|pending) && cur_ok) begin
          state_n     = ISSUE;
          cmd_valid_n = 1'b1;
          // Keep direction while requests remain ahead; otherwise reverse.
          if (!dir) begin
            if (up_found) cmd_floor_n = up_floor;
            else begin
              cmd_floor_n = dn_floor;
              dir_n       = 1'b1;
            end
          end else begin
            if (dn_found) cmd_floor_n = dn_floor;
            else begin
              cmd_floor_n = up_floor;
              dir_n       = 1'b0;
            end
          end
        end
      end
      ISSUE: begin
        if (car.cmd_ready) begin
          cmd_valid_n = 1'b0;
          state_n     = TRAVEL;
        end
      end
      TRAVEL: begin
        if (car.arrived && (car.cur_floor == cmd_floor_q)) begin
          state_n = DOOR;
          cnt_n   = CW'(DOOR_CYCLES - 1);
        end
      end
      DOOR: begin
        pend_n = (pending | req) & ~cur_mask;
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pending     <= '0;
      dir         <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_floor_q <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pending     <= pend_n;
      dir         <= dir_n;
      cmd_valid_q <= cmd_valid_n;
      cmd_floor_q <= cmd_floor_n;
    end
  end

  assign car.cmd_valid = cmd_valid_q;
  assign car.cmd_floor = cmd_floor_q;
  assign door_open     = (state == DOOR);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Bench for lift_request_scheduler: vector table, directed corner sequences and
// a randomized run against a request-set model using the SCAN rule.
module tb_lift_request_scheduler;
  localparam int NF = 5;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] req;
  logic [NF-1:0] pending;
  logic          door_open, dir, busy;

  lift_request_scheduler_if car();

  lift_request_scheduler #(.NFLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .car       (car),
    .door_open (door_open),
    .dir       (dir),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int            cur;
    logic [NF-1:0] rq;
    bit            ev;
    int            ef;
    bit            edir;
    bit            ed;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    car.arrived   = 1'b0;
    car.cmd_ready = 1'b0;
    car.cur_floor = 3'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference SCAN choice by distance on either side of the car.
  task automatic scan_pick(input bit [NF-1:0] p, input int cur, input int d,
                           output int tgt, output int nd);
    int up, dn;
    up = -1;
    dn = -1;
    for (int f = 0; f < NF; f++) begin
      if (p[f]) begin
        if (f > cur && (up < 0 || f - cur < up - cur)) up = f;
        if (f < cur && (dn < 0 || cur - f < cur - dn)) dn = f;
      end
    end
    if (d == 0) begin
      if (up >= 0) begin tgt = up; nd = 0; end
      else         begin tgt = dn; nd = 1; end
    end else begin
      if (dn >= 0) begin tgt = dn; nd = 1; end
      else         begin tgt = up; nd = 0; end
    end
  endtask

  task automatic wait_sig(input string nm, input bit want_door, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((want_door ? door_open : car.cmd_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({nm, " wait"}, 32'(ok), 1);
  endtask

  task automatic door_check(input string nm, input bit absorb);
    int n;
    n = 0;
    while (door_open === 1'b1 && n < DC + 3) begin
      n++;
      if (absorb && n == 1) begin
        req = '0;
        req[car.cur_floor] = 1'b1;
      end
      tick();
      req = '0;
    end
    chk({nm, " dwell"}, 32'(n), 32'(DC));
  endtask

  task automatic serve(input string nm, input int tgt, input int ed, input int hold);
    bit ok;
    wait_sig({nm, " valid"}, 1'b0, ok);
    chk({nm, " floor"}, 32'(car.cmd_floor), 32'(tgt));
    chk({nm, " dir"}, 32'(dir), 32'(ed));
    repeat (hold) begin
      chk({nm, " held valid"}, 32'(car.cmd_valid), 1);
      chk({nm, " held floor"}, 32'(car.cmd_floor), 32'(tgt));
      tick();
    end
    car.cmd_ready = 1'b1;
    tick();
    car.cmd_ready = 1'b0;
    chk({nm, " valid drop"}, 32'(car.cmd_valid), 0);
  endtask

  task automatic arrive(input string nm, input int tgt, input bit absorb);
    car.cur_floor = 3'(tgt);
    car.arrived   = 1'b1;
    tick();
    car.arrived   = 1'b0;
    chk({nm, " door"}, 32'(door_open), 1);
    door_check(nm, absorb);
  endtask

  initial begin
    bit            ok;
    int            tgt, nd, m_cur, m_dir, cnt;
    bit [NF-1:0]   m_pend;
    logic [NF-1:0] r;

    vt[0]  = '{0, 5'b01000, 1'b1, 3, 1'b0, 1'b0};
    vt[1]  = '{2, 5'b10011, 1'b1, 4, 1'b0, 1'b0};
    vt[2]  = '{4, 5'b00011, 1'b1, 1, 1'b1, 1'b0};
    vt[3]  = '{2, 5'b00001, 1'b1, 0, 1'b1, 1'b0};
    vt[4]  = '{1, 5'b11100, 1'b1, 2, 1'b0, 1'b0};
    vt[5]  = '{3, 5'b10000, 1'b1, 4, 1'b0, 1'b0};
    vt[6]  = '{0, 5'b00001, 1'b0, 0, 1'b0, 1'b1};
    vt[7]  = '{4, 5'b10000, 1'b0, 0, 1'b0, 1'b1};
    vt[8]  = '{5, 5'b00100, 1'b0, 0, 1'b0, 1'b0};
    vt[9]  = '{7, 5'b11111, 1'b0, 0, 1'b0, 1'b0};
    vt[10] = '{2, 5'b00110, 1'b0, 0, 1'b0, 1'b1};

    rst = 1'b1;
    req = '0;
    car.arrived   = 1'b0;
    car.cmd_ready = 1'b0;
    car.cur_floor = 3'd0;
    tick();

    // Reset with all requests asserted: nothing survives.
    rst = 1'b1;
    req = '1;
    tick();
    tick();
    rst = 1'b0;
    req = '0;
    chk("rst pending", 32'(pending), 0);
    chk("rst dir", 32'(dir), 0);
    chk("rst cmd_valid", 32'(car.cmd_valid), 0);
    chk("rst cmd_floor", 32'(car.cmd_floor), 0);
    chk("rst door", 32'(door_open), 0);
    chk("rst busy", 32'(busy), 0);
    tick();
    chk("rst pending later", 32'(pending), 0);
    chk("rst no cmd later", 32'(car.cmd_valid), 0);

    // First decision from reset for each vector.
    foreach (vt[k]) begin
      do_reset();
      car.cur_floor = 3'(vt[k].cur);
      req = vt[k].rq;
      tick();
      req = '0;
      tick();
      chk($sformatf("vec%0d cmd_valid", k), 32'(car.cmd_valid), 32'(vt[k].ev));
      chk($sformatf("vec%0d door", k), 32'(door_open), 32'(vt[k].ed));
      chk($sformatf("vec%0d pending", k), 32'(pending), 32'(vt[k].rq));
      chk($sformatf("vec%0d dir", k), 32'(dir), 32'(vt[k].edir));
      chk($sformatf("vec%0d busy", k), 32'(busy), 32'(vt[k].ev | vt[k].ed));
      if (vt[k].ev) chk($sformatf("vec%0d floor", k), 32'(car.cmd_floor), 32'(vt[k].ef));
    end

    // Single call with cmd_ready already high: one-cycle offer.
    do_reset();
    car.cmd_ready = 1'b1;
    req = 5'b01000;
    tick();
    req = '0;
    chk("single pre", 32'(car.cmd_valid), 0);
    tick();
    chk("single valid", 32'(car.cmd_valid), 1);
    chk("single floor", 32'(car.cmd_floor), 3);
    tick();
    car.cmd_ready = 1'b0;
    chk("single one cycle", 32'(car.cmd_valid), 0);
    arrive("single", 3, 1'b0);
    chk("single pending", 32'(pending), 0);
    chk("single idle", 32'(busy), 0);

    // SCAN order from floor 2 heading up.
    do_reset();
    car.cur_floor = 3'd2;
    req = 5'b10011;
    tick();
    req = '0;
    serve("scan4", 4, 0, 0);
    arrive("scan4", 4, 1'b0);
    serve("scan1", 1, 1, 0);
    arrive("scan1", 1, 1'b0);
    serve("scan0", 0, 1, 0);
    arrive("scan0", 0, 1'b0);
    chk("scan pending", 32'(pending), 0);
    cnt = 0;
    repeat (5) begin
      tick();
      if (car.cmd_valid === 1'b1) cnt++;
    end
    chk("scan quiet", 32'(cnt), 0);

    // Backpressure for 7 cycles, then abandon travel via reset.
    do_reset();
    req = 5'b00100;
    tick();
    req = '0;
    serve("bp", 2, 0, 7);
    chk("travel busy", 32'(busy), 1);
    req = 5'b10000;
    tick();
    req = '0;
    chk("travel pending", 32'(pending), 5'b10100);
    car.cur_floor = 3'd1;
    car.arrived   = 1'b1;
    tick();
    car.arrived   = 1'b0;
    chk("mismatch no door", 32'(door_open), 0);
    chk("mismatch busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst pending", 32'(pending), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst valid", 32'(car.cmd_valid), 0);
    chk("midrst dir", 32'(dir), 0);
    cnt = 0;
    repeat (6) begin
      tick();
      if (car.cmd_valid === 1'b1 || door_open === 1'b1) cnt++;
    end
    chk("midrst quiet", 32'(cnt), 0);

    // Same-floor call with a repeat request absorbed during dwell.
    do_reset();
    car.cur_floor = 3'd1;
    req = 5'b00010;
    tick();
    req = '0;
    tick();
    chk("local door", 32'(door_open), 1);
    chk("local no cmd", 32'(car.cmd_valid), 0);
    door_check("local", 1'b1);
    chk("local absorbed", 32'(pending), 0);
    tick();
    chk("local stays idle", 32'(busy), 0);

    // Randomized trips against the request-set model.
    do_reset();
    m_pend = '0;
    m_cur  = 0;
    m_dir  = 0;
    for (int t = 0; t < 30; t++) begin
      if (m_pend == '0) begin
        r = NF'($urandom_range(1, 31));
        req = r;
        tick();
        req = '0;
        m_pend |= r;
      end
      if (m_pend[m_cur]) begin
        wait_sig("rnd local", 1'b1, ok);
        chk("rnd local no cmd", 32'(car.cmd_valid), 0);
        door_check("rnd local", 1'($urandom_range(0, 1)));
        m_pend[m_cur] = 1'b0;
        chk("rnd local pending", 32'(pending), 32'(m_pend));
      end else begin
        scan_pick(m_pend, m_cur, m_dir, tgt, nd);
        m_dir = nd;
        serve("rnd", tgt, nd, $urandom_range(0, 4));
        repeat ($urandom_range(1, 6)) begin
          r = NF'($urandom_range(0, 31));
          if ($urandom_range(0, 2) != 0) r = '0;
          req = r;
          car.arrived = ($urandom_range(0, 3) == 0);
          m_pend |= r;
          tick();
          req = '0;
          car.arrived = 1'b0;
        end
        chk("rnd travel no door", 32'(door_open), 0);
        chk("rnd travel pending", 32'(pending), 32'(m_pend));
        arrive("rnd", tgt, 1'($urandom_range(0, 1)));
        m_cur = tgt;
        m_pend[tgt] = 1'b0;
        chk("rnd pending", 32'(pending), 32'(m_pend));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
